// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match sequencer and its neighbours.
// Also holds the helper that sizes the shared frame counter.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SERVE_WAIT = 3'd1,
      SERVE      = 3'd2,
      PLAY       = 3'd3,
      POINT      = 3'd4,
      GAME_OVER  = 3'd5
   } state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   localparam int FIELD_SIZE = 64;
   localparam int CENTRE     = FIELD_SIZE / 2 - 1;

   typedef struct packed {
      logic [5:0] x;
      logic [5:0] y;
   } ball_pos_t;

   // Where the ball datapath recentres on every serve.
   function automatic ball_pos_t serve_pos();
      ball_pos_t p;
      p.x = 6'(CENTRE);
      p.y = 6'(CENTRE);
      return p;
   endfunction

   function automatic int cnt_width(int a, int b, int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Control/status bundle between the match sequencer and the rest of the game.
// The slave side is the sequencer; the master side drives requests and events.
interface pong_game_ctrl_if;

   logic       start;
   logic       frame_tick;
   logic       paddle_hit;
   logic       miss_left;
   logic       miss_right;
   logic       ball_serve;
   logic       serve_dir;
   logic       move_en;
   logic [3:0] score_l;
   logic [3:0] score_r;
   logic       game_over;
   logic       winner;
   logic [2:0] state_o;

   modport master (
      output start, frame_tick, paddle_hit, miss_left, miss_right,
      input  ball_serve, serve_dir, move_en, score_l, score_r,
             game_over, winner, state_o
   );

   modport slave (
      input  start, frame_tick, paddle_hit, miss_left, miss_right,
      output ball_serve, serve_dir, move_en, score_l, score_r,
             game_over, winner, state_o
   );

endinterface

// File: rtl/pong_speed_sched.sv
// Rally pacing: shared frame counter, paddle-hit counter, current speed and
// the move_en strobe that steps the ball datapath.
module pong_speed_sched #(
   parameter int SPEED_INIT = 4,
   parameter int SPEED_MIN  = 1,
   parameter int RALLY_STEP = 4,
   parameter int CNT_W      = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_reload,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic             i_frame_tick,
   input  logic             i_paddle_hit,
   output logic [CNT_W-1:0] o_frame_cnt,
   output logic             o_move_en
);

   localparam int HIT_W = (RALLY_STEP > 1) ? $clog2(RALLY_STEP) : 1;

   logic [CNT_W-1:0] r_frame_cnt;
   logic [CNT_W-1:0] r_speed;
   logic [HIT_W-1:0] r_hit_cnt;
   logic             r_move_en;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_step_due;

   assign w_cnt_inc = r_frame_cnt + 1'b1;
   // >= rather than == so a speed-up that lands below the running count
   // still fires on the next tick instead of letting the counter run away.
   assign w_step_due = i_enable && i_frame_tick && (w_cnt_inc >= r_speed);

   // NOTE: nonblocking assignments in clocked logic so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_cnt <= '0;
         r_speed     <= CNT_W'(SPEED_INIT);
         r_hit_cnt   <= '0;
         r_move_en   <= 1'b0;
      end else begin
         r_move_en <= w_step_due;

         if (i_clear || w_step_due)
            r_frame_cnt <= '0;
         else if (i_frame_tick)
            r_frame_cnt <= w_cnt_inc;

         if (i_reload) begin
            r_speed   <= CNT_W'(SPEED_INIT);
            r_hit_cnt <= '0;
         end else if (i_enable && i_paddle_hit) begin
            if (r_hit_cnt == HIT_W'(RALLY_STEP - 1)) begin
               r_hit_cnt <= '0;
               if (r_speed > CNT_W'(SPEED_MIN))
                  r_speed <= r_speed - 1'b1;
            end else begin
               r_hit_cnt <= r_hit_cnt + 1'b1;
            end
         end
      end
   end

   assign o_frame_cnt = r_frame_cnt;
   assign o_move_en   = r_move_en;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve timing, point handling, scoring and match end.
// Ball pacing is delegated to pong_speed_sched.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE   = 11,
   parameter int SERVE_DELAY = 60,
   parameter int POINT_HOLD  = 30,
   parameter int SPEED_INIT  = 4,
   parameter int SPEED_MIN   = 1,
   parameter int RALLY_STEP  = 4
) (
   input  logic             clk,
   input  logic             reset,
   pong_game_ctrl_if.slave  bus
);

   localparam int CNT_W = cnt_width(SERVE_DELAY, POINT_HOLD, SPEED_INIT);
   localparam logic [3:0] WIN = 4'(WIN_SCORE);

   state_t           r_state;
   logic             r_ball_serve;
   logic             r_serve_dir;
   logic             r_game_over;
   logic             r_winner;
   logic [3:0]       r_score_l;
   logic [3:0]       r_score_r;

   logic [CNT_W-1:0] w_frame_cnt;
   logic             w_move_en;
   logic             w_miss_any;
   logic             w_tick;
   logic             w_wait_done;
   logic             w_hold_done;
   logic             w_start;
   logic             w_leave;

   assign w_miss_any  = bus.miss_left | bus.miss_right;
   assign w_tick      = bus.frame_tick && (r_state inside {SERVE_WAIT, PLAY, POINT});
   assign w_wait_done = w_tick && (r_state == SERVE_WAIT) && (w_frame_cnt == CNT_W'(SERVE_DELAY - 1));
   assign w_hold_done = w_tick && (r_state == POINT) && (w_frame_cnt == CNT_W'(POINT_HOLD - 1));
   assign w_start     = bus.start && (r_state inside {IDLE, GAME_OVER});
   // Any state transition this cycle; clears the shared frame counter on entry.
   assign w_leave     = w_start || w_wait_done || w_hold_done || (r_state == SERVE) ||
                        ((r_state == PLAY) && w_miss_any);

   pong_speed_sched #(
      .SPEED_INIT (SPEED_INIT),
      .SPEED_MIN  (SPEED_MIN),
      .RALLY_STEP (RALLY_STEP),
      .CNT_W      (CNT_W)
   ) u_speed_sched (
      .clk          (clk),
      .reset        (reset),
      .i_reload     (r_state == SERVE),
      .i_clear      (w_leave),
      .i_enable     ((r_state == PLAY) && !w_miss_any),
      .i_frame_tick (w_tick),
      .i_paddle_hit (bus.paddle_hit),
      .o_frame_cnt  (w_frame_cnt),
      .o_move_en    (w_move_en)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_ball_serve <= 1'b0;
         r_serve_dir  <= DIR_RIGHT;
         r_game_over  <= 1'b0;
         r_winner     <= 1'b0;
         r_score_l    <= '0;
         r_score_r    <= '0;
      end else begin
         r_ball_serve <= 1'b0;
         case (r_state)
            IDLE, GAME_OVER: begin
               if (bus.start) begin
                  r_score_l   <= '0;
                  r_score_r   <= '0;
                  r_game_over <= 1'b0;
                  r_winner    <= 1'b0;
                  r_serve_dir <= DIR_RIGHT;
                  r_state     <= SERVE_WAIT;
               end
            end
            SERVE_WAIT: begin
               if (w_wait_done) begin
                  r_ball_serve <= 1'b1;
                  r_state      <= SERVE;
               end
            end
            SERVE: r_state <= PLAY;
            PLAY: begin
               // A double miss is a replay: no score, serve direction kept.
               if (w_miss_any) begin
                  r_state <= POINT;
                  if (bus.miss_left && !bus.miss_right) begin
                     r_serve_dir <= DIR_LEFT;
                     if (r_score_r < WIN)
                        r_score_r <= r_score_r + 1'b1;
                  end
                  if (bus.miss_right && !bus.miss_left) begin
                     r_serve_dir <= DIR_RIGHT;
                     if (r_score_l < WIN)
                        r_score_l <= r_score_l + 1'b1;
                  end
               end
            end
            POINT: begin
               if (w_hold_done) begin
                  if ((r_score_l == WIN) || (r_score_r == WIN)) begin
                     r_state     <= GAME_OVER;
                     r_game_over <= 1'b1;
                     r_winner    <= (r_score_r == WIN);
                  end else begin
                     r_state <= SERVE_WAIT;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ball_serve = r_ball_serve;
   assign bus.serve_dir  = r_serve_dir;
   assign bus.move_en    = w_move_en;
   assign bus.score_l    = r_score_l;
   assign bus.score_r    = r_score_r;
   assign bus.game_over  = r_game_over;
   assign bus.winner     = r_winner;
   assign bus.state_o    = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed-plus-random bench for pong_game_ctrl against a rule-level match model.
// Every cycle all outputs are compared; directed checks cover the key scenarios.
module tb_pong_game_ctrl;

   localparam int WIN    = 11;
   localparam int SDELAY = 60;
   localparam int PHOLD  = 30;
   localparam int SINIT  = 4;
   localparam int SMIN   = 1;
   localparam int RSTEP  = 4;

   localparam int S_IDLE = 0, S_SW = 1, S_SERVE = 2, S_PLAY = 3, S_POINT = 4, S_GO = 5;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   pong_game_ctrl_if bus ();

   pong_game_ctrl #(
      .WIN_SCORE   (WIN),
      .SERVE_DELAY (SDELAY),
      .POINT_HOLD  (PHOLD),
      .SPEED_INIT  (SINIT),
      .SPEED_MIN   (SMIN),
      .RALLY_STEP  (RSTEP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Match model: plain integers following the game rules.
   int m_state, m_sl, m_sr, m_dir, m_go, m_win, m_serve, m_move;
   int m_ticks, m_speed, m_hits;

   int seen_move;
   int seen_serve;
   int last_serve_dir;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit chance(int n);
      return ($urandom_range(n - 1, 0) == 0);
   endfunction

   task automatic model_reset();
      m_state = S_IDLE; m_sl = 0; m_sr = 0; m_dir = 1; m_go = 0; m_win = 0;
      m_serve = 0; m_move = 0; m_ticks = 0; m_speed = SINIT; m_hits = 0;
   endtask

   task automatic model_step(bit st, bit ft, bit ph, bit ml, bit mr);
      m_serve = 0;
      m_move  = 0;
      case (m_state)
         S_IDLE, S_GO: if (st) begin
            m_sl = 0; m_sr = 0; m_go = 0; m_win = 0; m_dir = 1; m_ticks = 0;
            m_state = S_SW;
         end
         S_SW: if (ft) begin
            m_ticks++;
            if (m_ticks == SDELAY) begin m_ticks = 0; m_serve = 1; m_state = S_SERVE; end
         end
         S_SERVE: begin
            m_speed = SINIT; m_hits = 0; m_ticks = 0; m_state = S_PLAY;
         end
         S_PLAY: if (ml || mr) begin
            if (ml && !mr) begin m_sr++; m_dir = 0; end
            if (mr && !ml) begin m_sl++; m_dir = 1; end
            m_ticks = 0; m_state = S_POINT;
         end else begin
            if (ft) begin
               m_ticks++;
               if (m_ticks >= m_speed) begin m_move = 1; m_ticks = 0; end
            end
            if (ph) begin
               m_hits++;
               if (m_hits == RSTEP) begin
                  m_hits = 0;
                  m_speed = (m_speed > SMIN) ? m_speed - 1 : SMIN;
               end
            end
         end
         S_POINT: if (ft) begin
            m_ticks++;
            if (m_ticks == PHOLD) begin
               m_ticks = 0;
               if (m_sl == WIN || m_sr == WIN) begin
                  m_state = S_GO; m_go = 1; m_win = (m_sr == WIN) ? 1 : 0;
               end else begin
                  m_state = S_SW;
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic step(bit st, bit ft, bit ph, bit ml, bit mr);
      bus.start = st; bus.frame_tick = ft; bus.paddle_hit = ph;
      bus.miss_left = ml; bus.miss_right = mr;
      @(posedge clk);
      if (reset) model_reset();
      else model_step(st, ft, ph, ml, mr);
      #1;
      check("state",      32'(bus.state_o),    m_state);
      check("ball_serve", 32'(bus.ball_serve), m_serve);
      check("serve_dir",  32'(bus.serve_dir),  m_dir);
      check("move_en",    32'(bus.move_en),    m_move);
      check("score_l",    32'(bus.score_l),    m_sl);
      check("score_r",    32'(bus.score_r),    m_sr);
      check("game_over",  32'(bus.game_over),  m_go);
      check("winner",     32'(bus.winner),     m_win);
      if (bus.move_en === 1'b1) seen_move++;
      if (bus.ball_serve === 1'b1) begin
         seen_serve++;
         last_serve_dir = int'(bus.serve_dir);
      end
   endtask

   // Random ignored inputs, only used while the model is outside PLAY.
   task automatic noise_step(bit ft);
      step(1'b0, ft, chance(4), chance(8), chance(8));
   endtask

   task automatic tick_noisy(int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(2, 0)) noise_step(1'b0);
         noise_step(1'b1);
      end
   endtask

   task automatic tick_quiet(int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(2, 0)) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic run_until(int target, int budget);
      for (int i = 0; i < budget && m_state != target; i++) noise_step(chance(2));
      check("reach_state", 32'(bus.state_o), target);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start = 1'b0; bus.frame_tick = 1'b0; bus.paddle_hit = 1'b0;
      bus.miss_left = 1'b0; bus.miss_right = 1'b0;
      model_reset();
      seen_move = 0; seen_serve = 0; last_serve_dir = -1;

      // Reset with random activity on every input
      reset = 1'b1;
      repeat (3) step(chance(2), chance(2), chance(2), chance(2), chance(2));
      reset = 1'b0;
      check("rst_state", 32'(bus.state_o), S_IDLE);
      check("rst_dir",   32'(bus.serve_dir), 1);

      // Ticks and events are ignored in IDLE
      repeat (5) noise_step(chance(2));
      check("idle_hold", 32'(bus.state_o), S_IDLE);

      // Start, then exactly SERVE_DELAY ticks to the serve
      step(1'b1, chance(2), 1'b0, 1'b0, 1'b0);
      check("start_sw", 32'(bus.state_o), S_SW);
      seen_move = 0; seen_serve = 0;
      tick_noisy(SDELAY - 1);
      check("no_serve_early", seen_serve, 0);
      tick_noisy(1);
      check("serve_pulse", 32'(bus.ball_serve), 1);
      check("serve_dir_first", 32'(bus.serve_dir), 1);
      step(1'b0, chance(2), 1'b0, 1'b0, 1'b0);
      check("serve_width", seen_serve, 1);
      check("play_after_serve", 32'(bus.state_o), S_PLAY);
      check("no_move_before_play", seen_move, 0);

      // Speed 4: 12 ticks give 3 steps
      seen_move = 0;
      tick_quiet(12);
      check("moves_speed4", seen_move, 3);

      // 4 hits: speed 3
      repeat (RSTEP) step(1'b0, chance(2), 1'b1, 1'b0, 1'b0);
      seen_move = 0;
      for (int i = 0; i < 8 && seen_move == 0; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("align_speed3", seen_move, 1);
      seen_move = 0;
      tick_quiet(9);
      check("moves_speed3", seen_move, 3);

      // 16 hits total: speed saturates at 1, stays there after 4 more
      repeat (12) step(1'b0, chance(2), 1'b1, 1'b0, 1'b0);
      seen_move = 0;
      tick_quiet(5);
      check("moves_speed1", seen_move, 5);
      repeat (RSTEP) step(1'b0, chance(2), 1'b1, 1'b0, 1'b0);
      seen_move = 0;
      tick_quiet(5);
      check("moves_saturated", seen_move, 5);

      // miss_left with a simultaneous hit: right scores, serve goes left
      step(1'b0, chance(2), 1'b1, 1'b1, 1'b0);
      check("miss_l_score_r", 32'(bus.score_r), 1);
      check("miss_l_state", 32'(bus.state_o), S_POINT);
      tick_noisy(PHOLD - 1);
      check("hold_not_done", 32'(bus.state_o), S_POINT);
      tick_noisy(1);
      check("hold_done", 32'(bus.state_o), S_SW);
      run_until(S_PLAY, 600);
      check("serve_dir_left", last_serve_dir, 0);
      seen_move = 0;
      tick_quiet(8);
      check("moves_after_reserve", seen_move, 2);

      // Double miss: replay, scores and direction unchanged, hits in POINT ignored
      step(1'b0, chance(2), chance(2), 1'b1, 1'b1);
      check("replay_score_l", 32'(bus.score_l), 0);
      check("replay_score_r", 32'(bus.score_r), 1);
      check("replay_state", 32'(bus.state_o), S_POINT);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_until(S_PLAY, 600);
      check("replay_dir", last_serve_dir, 0);
      seen_move = 0;
      tick_quiet(8);
      check("moves_after_replay", seen_move, 2);

      // Random rallies until the left player is one point from winning
      for (int p = 0; p < 40 && m_sl < WIN - 1; p++) begin
         repeat ($urandom_range(30, 0)) step(1'b0, chance(2), chance(3), 1'b0, 1'b0);
         if (m_sr < WIN - 2 && chance(4)) step(1'b0, chance(2), chance(2), 1'b1, 1'b0);
         else step(1'b0, chance(2), chance(2), 1'b0, 1'b1);
         run_until(S_PLAY, 600);
      end
      check("score_l_ten", 32'(bus.score_l), WIN - 1);

      // Winning point
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("win_score_l", 32'(bus.score_l), WIN);
      check("win_point", 32'(bus.state_o), S_POINT);
      run_until(S_GO, 400);
      check("game_over", 32'(bus.game_over), 1);
      check("winner_left", 32'(bus.winner), 0);
      repeat (10) step(1'b0, chance(2), chance(2), chance(2), chance(2));
      check("go_hold_score", 32'(bus.score_l), WIN);
      check("go_hold_state", 32'(bus.state_o), S_GO);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("restart_state", 32'(bus.state_o), S_SW);
      check("restart_score_l", 32'(bus.score_l), 0);
      check("restart_game_over", 32'(bus.game_over), 0);

      // Reset in the middle of a rally
      run_until(S_PLAY, 600);
      repeat (5) step(1'b0, chance(2), chance(2), 1'b0, 1'b0);
      reset = 1'b1;
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      reset = 1'b0;
      check("midplay_rst_state", 32'(bus.state_o), S_IDLE);
      check("midplay_rst_move", 32'(bus.move_en), 0);
      check("midplay_rst_dir", 32'(bus.serve_dir), 1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("after_rst_idle", 32'(bus.state_o), S_IDLE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
